// File: rtl/hilo_div_unit_pkg.sv
// Shared definitions for the HILO divider: FSM encodings, the divide-by-zero
// quotient and the decode op codes that drive start/signed_div.
package hilo_div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    function automatic logic div_op_signed(input logic [7:0] op);
        return op == EXE_DIV_OP;
    endfunction

endpackage

// File: rtl/hilo_div_unit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and keep the trial difference when it does not go negative.
module hilo_div_unit_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    assign rem_sh = {rem, quo[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, divisor};

    always_comb begin
        if (diff[WIDTH]) begin
            rem_out = rem_sh[WIDTH-1:0];
            quo_out = {quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_out = diff[WIDTH-1:0];
            quo_out = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/hilo_div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU producing {HI=remainder, LO=quotient}.
// done is registered off the DONE state, so it lands one cycle after the result is written.
module hilo_div_unit
    import hilo_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   srca,
    input  logic [WIDTH-1:0]   srcb,
    input  logic               cancel,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] hilores
);

    div_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic [WIDTH-1:0] rem_nxt, quo_nxt;
    logic [WIDTH-1:0] a_mag, b_mag, rem_fix, quo_fix;
    logic             neg_q, neg_r;
    logic             accept, div_zero, last_step;

    assign accept    = start && !cancel;
    assign div_zero  = srcb == '0;
    assign last_step = cnt == CNT_W'(WIDTH - 1);

    assign a_mag   = (signed_div && srca[WIDTH-1]) ? ~srca + WIDTH'(1) : srca;
    assign b_mag   = (signed_div && srcb[WIDTH-1]) ? ~srcb + WIDTH'(1) : srcb;
    assign quo_fix = neg_q ? ~quo + WIDTH'(1) : quo;
    assign rem_fix = neg_r ? ~rem + WIDTH'(1) : rem;

    hilo_div_unit_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem     (rem),
        .quo     (quo),
        .divisor (dvs),
        .rem_out (rem_nxt),
        .quo_out (quo_nxt)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state <= DIV_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            DIV_IDLE: if (accept) state_nxt = div_zero ? DIV_DONE : DIV_CALC;
            DIV_CALC: if (cancel) state_nxt = DIV_IDLE;
                      else if (last_step) state_nxt = DIV_FIX;
            DIV_FIX:  state_nxt = cancel ? DIV_IDLE : DIV_DONE;
            DIV_DONE: state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    always_comb begin
        busy = state != DIV_IDLE;
    end

    // Dividend bits shift out of quo's MSB while quotient bits shift in at the LSB.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            done    <= 1'b0;
            hilores <= '0;
        end else begin
            done <= state == DIV_DONE;
            unique case (state)
                DIV_IDLE: if (accept) begin
                    cnt   <= '0;
                    rem   <= '0;
                    quo   <= a_mag;
                    dvs   <= b_mag;
                    neg_q <= signed_div && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                    neg_r <= signed_div && srca[WIDTH-1];
                    if (div_zero) hilores <= {srca, {WIDTH{1'b1}}};
                end
                DIV_CALC: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + CNT_W'(1);
                end
                DIV_FIX: if (!cancel) hilores <= {rem_fix, quo_fix};
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed bench for hilo_div_unit: vector table plus cancel/reset/back-to-back sequences.
module tb_hilo_div_unit;
    import hilo_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        resetn, start, signed_div, cancel;
    logic [31:0] srca, srcb;
    logic        busy, done;
    logic [63:0] hilores;

    int n_cmp = 0;
    int n_fail = 0;

    hilo_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .srca       (srca),
        .srcb       (srcb),
        .cancel     (cancel),
        .busy       (busy),
        .done       (done),
        .hilores    (hilores)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Issues one op and waits for done. now=1 drives start in the current cycle
    // (caller sits at a negedge). poke_at/cancel_at pulse start/cancel in cycle lat.
    task automatic do_op(input string nm, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_lat,
                         input bit now, input int poke_at, input int cancel_at);
        int lat, bcnt;
        bit seen;
        if (!now) begin
            @(negedge clk);
            chk({nm, " pulse"}, 64'(done), 64'd0);
        end
        start = 1'b1; signed_div = div_op_signed(op); srca = a; srcb = b;
        @(posedge clk);
        #1;
        start = 1'b0; srca = 32'hDEAD_BEEF; srcb = 32'h0;
        lat = 0; bcnt = 0; seen = 0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            start  = (lat == poke_at);
            srca   = 32'h1;
            cancel = (lat == cancel_at);
            if (busy) bcnt++;
            if (done) seen = 1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        start = 1'b0; cancel = 1'b0;
        chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, " busy cycles"}, 64'(bcnt), 64'(exp_lat));
        chk({nm, " hilores"}, hilores, exp);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; signed_div = 1'b0; cancel = 1'b0;
        srca = '0; srcb = '0;

        vecs[0] = '{EXE_DIVU_OP, 32'd100,       32'd7,         {32'd2, 32'd14},                 34};
        vecs[1] = '{EXE_DIV_OP,  32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD},  34};
        vecs[2] = '{EXE_DIV_OP,  32'd7,         32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD},          34};
        vecs[3] = '{EXE_DIV_OP,  32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000},          34};
        vecs[4] = '{EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd1,         {32'h0, 32'hFFFF_FFFF},          34};
        vecs[5] = '{EXE_DIVU_OP, 32'h1234,      32'd0,         {32'h1234, DIV_ZERO_QUO},        1};
        vecs[6] = '{EXE_DIV_OP,  32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14},         34};
        vecs[7] = '{EXE_DIVU_OP, 32'hFFFF_FFF9, 32'd2,         {32'd1, 32'h7FFF_FFFC},          34};
        vecs[8] = '{EXE_DIV_OP,  32'd5,         32'd0,         {32'd5, DIV_ZERO_QUO},           1};
        vecs[9] = '{EXE_DIVU_OP, 32'd3,         32'd5,         {32'd3, 32'd0},                  34};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hilores", hilores, 64'd0);
        resetn = 1'b1;

        for (int i = 0; i < 10; i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].exp, vecs[i].lat, 1'b0, -1, -1);

        // cancel at CALC step 10: no done, result untouched
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; srca = 32'd1000; srcb = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel busy", 64'(busy), 64'd0);
        begin
            int dcnt = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (done) dcnt++;
            end
            chk("cancel no done", 64'(dcnt), 64'd0);
        end
        chk("cancel hilores", hilores, {32'd3, 32'd0});

        // cancel together with start in IDLE: nothing starts
        start = 1'b1; cancel = 1'b1; srca = 32'd9; srcb = 32'd0;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("cancel+start busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("cancel+start done", 64'(done), 64'd0);
        chk("cancel+start hilores", hilores, {32'd3, 32'd0});

        do_op("after cancel", EXE_DIVU_OP, 32'd1000, 32'd3, {32'd1, 32'd333}, 34, 1'b0, -1, -1);

        // start pulsed mid-operation is ignored
        do_op("busy start", EXE_DIV_OP, 32'hFFFF_FF9C, 32'd7,
              {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 34, 1'b0, 5, -1);

        // back-to-back: second start driven in the done cycle itself
        do_op("b2b first", EXE_DIVU_OP, 32'd50, 32'd6, {32'd2, 32'd8}, 34, 1'b0, -1, -1);
        do_op("b2b second", EXE_DIVU_OP, 32'd77, 32'd10, {32'd7, 32'd7}, 34, 1'b1, -1, -1);

        // cancel while in DONE: done already committed
        do_op("cancel in done", EXE_DIVU_OP, 32'd91, 32'd9, {32'd1, 32'd10}, 34, 1'b0, -1, 33);

        // reset mid-CALC clears everything
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; srca = 32'd500; srcb = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset done", 64'(done), 64'd0);
        chk("midreset hilores", hilores, 64'd0);
        resetn = 1'b1;

        do_op("after reset", EXE_DIV_OP, 32'd500, 32'hFFFF_FFF7,
              {32'd5, 32'hFFFF_FFC9}, 34, 1'b0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
